// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: core FSM state encodings, writeback source
// select codes and the indices of the read-only special registers.
package gpu_pkg;

   // Core FSM states that sequence each thread lane
   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      FETCH   = 3'b001,
      DECODE  = 3'b010,
      REQUEST = 3'b011,
      WAIT    = 3'b100,
      EXECUTE = 3'b101,
      UPDATE  = 3'b110,
      DONE    = 3'b111
   } core_state_t;

   // Writeback source select; 2'b11 is reserved and never writes
   typedef enum logic [1:0] {
      MUX_ALU = 2'b00,
      MUX_LSU = 2'b01,
      MUX_IMM = 2'b10
   } reg_input_mux_t;

   localparam int unsigned REG_ADDR_BITS = 4;
   localparam int unsigned NUM_REGS      = 16;
   localparam int unsigned NZP_BITS      = 3;

   // Special registers; everything below R_BLOCK_ID is general purpose
   localparam logic [REG_ADDR_BITS-1:0] R_BLOCK_ID  = 4'd13;
   localparam logic [REG_ADDR_BITS-1:0] R_BLOCK_DIM = 4'd14;
   localparam logic [REG_ADDR_BITS-1:0] R_THREAD_ID = 4'd15;

endpackage

// File: rtl/thread_regfile.sv
// Per-thread register file and writeback stage for one GPU thread lane.
// Operands are read in REQUEST, results and NZP flags are committed in UPDATE.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   enable                     lane active; low holds every register and output
//   block_id                   current block index, mirrored into R13
//   core_state                 core FSM state
//   decoded_rd/rs/rt_address   destination and source register indices
//   decoded_reg_write_enable   writeback request
//   decoded_reg_input_mux      writeback source (ALU, LSU, IMM)
//   decoded_immediate          CONST value
//   decoded_nzp_write_enable   load NZP flags from alu_out[2:0]
//   alu_out, lsu_out           ALU and load results
//   rs, rt                     registered operands
//   nzp                        {pos, zero, neg} condition flags
module thread_regfile
   import gpu_pkg::*;
#(
   parameter int unsigned DATA_BITS         = 8,
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned THREAD_ID         = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [DATA_BITS-1:0]     block_id,
   input  logic [2:0]               core_state,
   input  logic [REG_ADDR_BITS-1:0] decoded_rd_address,
   input  logic [REG_ADDR_BITS-1:0] decoded_rs_address,
   input  logic [REG_ADDR_BITS-1:0] decoded_rt_address,
   input  logic                     decoded_reg_write_enable,
   input  logic [1:0]               decoded_reg_input_mux,
   input  logic [DATA_BITS-1:0]     decoded_immediate,
   input  logic                     decoded_nzp_write_enable,
   input  logic [DATA_BITS-1:0]     alu_out,
   input  logic [DATA_BITS-1:0]     lsu_out,
   output logic [DATA_BITS-1:0]     rs,
   output logic [DATA_BITS-1:0]     rt,
   output logic [NZP_BITS-1:0]      nzp
);

   logic [DATA_BITS-1:0] regs [NUM_REGS];
   logic [DATA_BITS-1:0] wb_data;
   logic                 wb_valid;
   logic                 wb_commit;

   // Writeback source select; the reserved code yields no write
   always_comb begin
      wb_data  = '0;
      wb_valid = 1'b0;
      case (decoded_reg_input_mux)
         MUX_ALU: begin
            wb_data  = alu_out;
            wb_valid = 1'b1;
         end
         MUX_LSU: begin
            wb_data  = lsu_out;
            wb_valid = 1'b1;
         end
         MUX_IMM: begin
            wb_data  = decoded_immediate;
            wb_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Writes to R13..R15 are dropped silently
   assign wb_commit = decoded_reg_write_enable && wb_valid &&
                      (decoded_rd_address < R_BLOCK_ID);

   // Register file, operand latches and flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(R_BLOCK_DIM); i++) begin
            regs[i] <= '0;
         end
         regs[R_BLOCK_DIM] <= DATA_BITS'(THREADS_PER_BLOCK);
         regs[R_THREAD_ID] <= DATA_BITS'(THREAD_ID);
         rs                <= '0;
         rt                <= '0;
         nzp               <= '0;
      end else if (enable) begin
         // R13 tracks block_id in every state
         regs[R_BLOCK_ID] <= block_id;
         case (core_state)
            REQUEST: begin
               rs <= regs[decoded_rs_address];
               rt <= regs[decoded_rt_address];
            end
            UPDATE: begin
               if (wb_commit) begin
                  regs[decoded_rd_address] <= wb_data;
               end
               if (decoded_nzp_write_enable) begin
                  nzp <= alu_out[NZP_BITS-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
